// File: rtl/bt_cmd_ctrl.sv
// bt_cmd_ctrl -- command controller for a UART-driven motor with light.
//
// Pulls one byte at a time from a UART receiver, decodes it as a command,
// echoes it back (or '?' when the byte is not a command), and runs a
// motor direction FSM with a dead time on reversal and an inactivity
// timeout.
//
// Commands: 'A' up, 'B' down, 'C' stop, 'J' light on, 'K' light off.
//
// Ports
//   clkf        in   system clock
//   rst         in   asynchronous active-low reset
//   rx_rdy      in   receiver has a byte
//   rx_data     in   received byte
//   rx_rdy_clr  out  clears the receiver ready flag
//   tx_busy     in   transmitter busy
//   tx_wr_en    out  request transmission of tx_din
//   tx_din      out  byte to transmit (echo or '?')
//   izq         out  motor down drive
//   der         out  motor up drive
//   on_off_l    out  light enable
//   leds        out  last accepted valid command byte
module bt_cmd_ctrl #(
  parameter int DEAD_CYC    = 50000,
  parameter int TIMEOUT_CYC = 100000000
) (
  input  logic       clkf,
  input  logic       rst,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       rx_rdy_clr,
  input  logic       tx_busy,
  output logic       tx_wr_en,
  output logic [7:0] tx_din,
  output logic       izq,
  output logic       der,
  output logic       on_off_l,
  output logic [7:0] leds
);

  localparam logic [7:0] CMD_UP    = 8'h41;
  localparam logic [7:0] CMD_DOWN  = 8'h42;
  localparam logic [7:0] CMD_STOP  = 8'h43;
  localparam logic [7:0] CMD_LON   = 8'h4A;
  localparam logic [7:0] CMD_LOFF  = 8'h4B;
  localparam logic [7:0] CHAR_QRY  = 8'h3F;

  localparam int DC_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam int TO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [DC_W-1:0] DEAD_LAST = DC_W'(DEAD_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    L_IDLE, L_CLR, L_DECODE, L_TX_REQ, L_TX_WAIT
  } link_t;

  typedef enum logic [1:0] {
    M_STOP, M_UP, M_DOWN, M_DEAD
  } motor_t;

  link_t           link_q, link_d;
  motor_t          motor_q, motor_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic [7:0]      tx_din_q, tx_din_d;
  logic [7:0]      leds_q, leds_d;
  logic            light_q, light_d;
  logic            target_q, target_d;   // pending direction after DEAD: 1 = down
  logic [DC_W-1:0] dead_cnt_q, dead_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic cmd_up, cmd_down, cmd_stop, cmd_lon, cmd_loff, cmd_valid, decode;
  logic dead_done, to_hit;

  assign cmd_up    = (rx_byte_q == CMD_UP);
  assign cmd_down  = (rx_byte_q == CMD_DOWN);
  assign cmd_stop  = (rx_byte_q == CMD_STOP);
  assign cmd_lon   = (rx_byte_q == CMD_LON);
  assign cmd_loff  = (rx_byte_q == CMD_LOFF);
  assign cmd_valid = cmd_up | cmd_down | cmd_stop | cmd_lon | cmd_loff;

  // ---------------------------------------------------------------- link FSM
  always_comb begin
    link_d     = link_q;
    rx_byte_d  = rx_byte_q;
    tx_din_d   = tx_din_q;
    leds_d     = leds_q;
    light_d    = light_q;
    rx_rdy_clr = 1'b0;
    tx_wr_en   = 1'b0;
    decode     = 1'b0;
    case (link_q)
      L_IDLE: begin
        if (rx_rdy) begin
          rx_byte_d = rx_data;
          link_d    = L_CLR;
        end
      end
      L_CLR: begin
        rx_rdy_clr = 1'b1;
        if (!rx_rdy) link_d = L_DECODE;
      end
      L_DECODE: begin
        decode = 1'b1;
        if (cmd_valid) begin
          tx_din_d = rx_byte_q;
          leds_d   = rx_byte_q;
          if (cmd_lon)  light_d = 1'b1;
          if (cmd_loff) light_d = 1'b0;
        end else begin
          tx_din_d = CHAR_QRY;
        end
        link_d = L_TX_REQ;
      end
      L_TX_REQ: begin
        // Hold the write request until the transmitter acknowledges by
        // going busy; the request drops in the same cycle busy is seen.
        if (tx_busy) link_d = L_TX_WAIT;
        else         tx_wr_en = 1'b1;
      end
      L_TX_WAIT: begin
        if (!tx_busy) link_d = L_IDLE;
      end
      default: link_d = L_IDLE;
    endcase
  end

  // --------------------------------------------------------------- motor FSM
  assign dead_done = (motor_q == M_DEAD) && (dead_cnt_q == DEAD_LAST);
  assign to_hit    = (TIMEOUT_CYC != 0) && (motor_q != M_STOP) && (to_cnt_q == TO_LAST);

  always_comb begin
    motor_d    = motor_q;
    target_d   = target_q;
    dead_cnt_d = dead_cnt_q;
    to_cnt_d   = to_cnt_q;

    // Timeout counts only while the motor may be driven; it saturates at
    // the limit so STOP leaves it parked until the next motor command.
    if ((TIMEOUT_CYC != 0) && (motor_q != M_STOP) && (to_cnt_q != TO_MAX))
      to_cnt_d = to_cnt_q + TO_W'(1);

    if (motor_q == M_DEAD) begin
      if (dead_done) motor_d = target_q ? M_DOWN : M_UP;
      else           dead_cnt_d = dead_cnt_q + DC_W'(1);
    end

    if (to_hit) begin
      motor_d  = M_STOP;
      target_d = 1'b0;
    end

    // A decoded motor command overrides both timers for this cycle.
    if (decode && (cmd_up || cmd_down || cmd_stop)) begin
      to_cnt_d = '0;
      if (cmd_stop) begin
        motor_d  = M_STOP;
        target_d = 1'b0;
      end else begin
        case (motor_q)
          M_STOP: motor_d = cmd_up ? M_UP : M_DOWN;
          M_UP: begin
            if (cmd_down) begin
              motor_d    = M_DEAD;
              target_d   = 1'b1;
              dead_cnt_d = '0;
            end else begin
              motor_d = M_UP;
            end
          end
          M_DOWN: begin
            if (cmd_up) begin
              motor_d    = M_DEAD;
              target_d   = 1'b0;
              dead_cnt_d = '0;
            end else begin
              motor_d = M_DOWN;
            end
          end
          default: begin
            // In DEAD: retarget without restarting the count; if the dead
            // time ends this very cycle, go straight to the new target.
            target_d = cmd_down;
            if (dead_done) motor_d = cmd_down ? M_DOWN : M_UP;
            else           motor_d = M_DEAD;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------- registers
  always_ff @(posedge clkf or negedge rst) begin
    if (!rst) begin
      link_q     <= L_IDLE;
      motor_q    <= M_STOP;
      rx_byte_q  <= '0;
      tx_din_q   <= '0;
      leds_q     <= '0;
      light_q    <= 1'b0;
      target_q   <= 1'b0;
      dead_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      link_q     <= link_d;
      motor_q    <= motor_d;
      rx_byte_q  <= rx_byte_d;
      tx_din_q   <= tx_din_d;
      leds_q     <= leds_d;
      light_q    <= light_d;
      target_q   <= target_d;
      dead_cnt_q <= dead_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign izq      = (motor_q == M_DOWN);
  assign der      = (motor_q == M_UP);
  assign on_off_l = light_q;
  assign tx_din   = tx_din_q;
  assign leds     = leds_q;

endmodule

// File: doc/bt_cmd_ctrl.md
BT_CMD_CTRL -- requirements
Module: bt_cmd_ctrl

Interface
REQ-001 Parameter DEAD_CYC, default 50000, number of clkf cycles both motor outputs are held low on a direction reversal.
REQ-002 Parameter TIMEOUT_CYC, default 100000000, number of clkf cycles without a valid motor command before the motor is forced to stop; 0 disables the timeout.
REQ-003 Port clkf, input, 1 bit, system clock (50 MHz); the block SHALL use one clock.
REQ-004 Port rst, input, 1 bit, reset, asynchronous and active-low.
REQ-005 Port rx_rdy, input, 1 bit, UART receiver byte-ready flag.
REQ-006 Port rx_data, input, 8 bits, UART received byte.
REQ-007 Port rx_rdy_clr, output, 1 bit, clears the receiver ready flag.
REQ-008 Port tx_busy, input, 1 bit, UART transmitter busy.
REQ-009 Port tx_wr_en, output, 1 bit, UART transmitter enable.
REQ-010 Port tx_din, output, 8 bits, byte to transmit.
REQ-011 Port izq, output, 1 bit, motor down drive.
REQ-012 Port der, output, 1 bit, motor up drive.
REQ-013 Port on_off_l, output, 1 bit, light enable.
REQ-014 Port leds, output, 8 bits, last accepted valid command byte.

Function
REQ-015 The command set SHALL be: 0x41 'A' up, 0x42 'B' down, 0x43 'C' stop, 0x4A 'J' light on, 0x4B 'K' light off; any other byte is invalid.
REQ-016 The link FSM SHALL have states IDLE, CLR, DECODE, TX_REQ and TX_WAIT.
REQ-017 In IDLE, when rx_rdy=1, the FSM SHALL capture rx_data into an internal register and move to CLR on the next edge.
REQ-018 In CLR, rx_rdy_clr SHALL be 1, and the FSM SHALL move to DECODE on the first cycle that rx_rdy=0; rx_rdy_clr is 0 in every other state.
REQ-019 DECODE SHALL last one cycle: it applies a valid command, loads leds, sets tx_din to the captured byte (echo) for a valid command or to 0x3F '?' for an invalid one, and moves to TX_REQ.
REQ-020 In TX_REQ, tx_wr_en SHALL be 1 until the first cycle that tx_busy=1, and the FSM SHALL then move to TX_WAIT with tx_wr_en=0.
REQ-021 In TX_WAIT, the FSM SHALL return to IDLE on the first cycle that tx_busy=0.
REQ-022 Bytes arriving while the FSM is outside IDLE SHALL stay pending in the receiver, because rx_rdy_clr is not asserted, and SHALL be serviced on the next return to IDLE.
REQ-023 tx_din SHALL hold its value from DECODE until the next DECODE.
REQ-024 The motor FSM SHALL have states STOP (izq=0, der=0), UP (der=1), DOWN (izq=1) and DEAD (both outputs 0); izq and der SHALL never both be 1.
REQ-025 The motor FSM SHALL respond to 'A', 'B' and 'C' from any state as follows.
- 'A' from STOP or UP: go to UP.
- 'B' from STOP or DOWN: go to DOWN.
- 'A' from DOWN or 'B' from UP: go to DEAD with the pending target recorded.
- 'C' from any state: go to STOP and clear any pending target.
REQ-026 DEAD SHALL last exactly DEAD_CYC cycles, then enter the pending target; a new 'A' or 'B' received during DEAD SHALL replace the target without restarting the count.
REQ-027 The outputs izq and der SHALL update on the clock edge that ends DECODE.
REQ-028 The timeout counter SHALL reset on every valid 'A', 'B' or 'C'.
REQ-029 When the timeout counter reaches TIMEOUT_CYC in UP, DOWN or DEAD, the motor SHALL go to STOP; the counter SHALL saturate and stay inactive while in STOP.
REQ-030 'J' SHALL set on_off_l to 1 and 'K' SHALL clear it; light commands SHALL NOT affect the motor or the timeout.
REQ-031 Invalid bytes SHALL leave izq, der, on_off_l and leds unchanged.

Reset
REQ-032 With rst=0, the block SHALL immediately place both FSMs in IDLE and STOP and clear all counters.
REQ-033 With rst=0, rx_rdy_clr, tx_wr_en, izq, der, on_off_l, tx_din and leds SHALL all be 0.
REQ-034 Reset asserted mid-transmit or mid-DEAD SHALL abort the operation, and no pending target SHALL survive.
REQ-035 Reset release SHALL take effect on the first clkf edge after rst rises.

Verification (DEAD_CYC=8, TIMEOUT_CYC=64 on bench)
REQ-036 rx_rdy with 0x41 -> rx_rdy_clr pulse, der=1 and izq=0 after DECODE, tx_wr_en until tx_busy, tx_din=0x41, leds=0x41.
REQ-037 In UP, receive 0x42 -> izq=der=0 for exactly 8 cycles, then izq=1; the echo byte is 0x42.
REQ-038 Receive 0x4A then 0x4B back-to-back, the second arriving during TX_WAIT -> on_off_l goes 1 then 0, two echoes in order, no byte lost.
REQ-039 Receive 0x55 -> tx_din=0x3F, and izq, der, on_off_l and leds unchanged.
REQ-040 In DOWN with no further commands -> izq falls to 0 exactly 64 cycles after the last valid motor command.
REQ-041 Assert rst=0 during TX_REQ and during DEAD -> all outputs 0 asynchronously; after release, the FSM is in IDLE and the motor in STOP.
